// File: rtl/apb2axi_txn_scheduler_if.sv
// Purpose: handshake bundle between directory manager, scheduler and AR/AW builders.
// Latency: none (wires only).
// Backpressure: valid/ready on both the directory pop side and the issue side.
interface apb2axi_txn_scheduler_if;

    // Layout must match entry_t inside apb2axi_txn_scheduler.
    typedef struct packed {
        logic        is_write;
        logic [3:0]  tag;
        logic [31:0] addr;
    } directory_entry_t;

    logic             dir_mgr_pop_valid;
    directory_entry_t dir_mgr_pop_entry;
    logic             dir_mgr_pop_ready;
    logic             rd_issue_valid;
    logic             wr_issue_valid;
    directory_entry_t issue_entry;
    logic             rd_issue_ready;
    logic             wr_issue_ready;
    logic             rd_cpl;
    logic             wr_cpl;

    // Scheduler side
    modport master (
        input  dir_mgr_pop_valid, dir_mgr_pop_entry, rd_issue_ready, wr_issue_ready,
               rd_cpl, wr_cpl,
        output dir_mgr_pop_ready, rd_issue_valid, wr_issue_valid, issue_entry
    );

    // Directory / builder side
    modport slave (
        output dir_mgr_pop_valid, dir_mgr_pop_entry, rd_issue_ready, wr_issue_ready,
               rd_cpl, wr_cpl,
        input  dir_mgr_pop_ready, rd_issue_valid, wr_issue_valid, issue_entry
    );

endinterface

// File: rtl/apb2axi_txn_scheduler.sv
// Purpose: in-order staging FIFO that issues directory entries to AR or AW/W builders.
// Latency: 1 cycle minimum from push to issue_entry/valid.
// Backpressure: pop_ready drops when FIFO full; head is held until its builder accepts.
module apb2axi_txn_scheduler #(
    parameter int SCHED_DEPTH = 2,
    parameter int MAX_RD_OUT  = 4,
    parameter int MAX_WR_OUT  = 4
) (
    input  logic                              pclk,
    input  logic                              preset,
    input  logic                              sched_en,
    input  logic                              order_strict,
    apb2axi_txn_scheduler_if.master           bus,
    output logic [$clog2(MAX_RD_OUT+1)-1:0]   rd_out_cnt,
    output logic [$clog2(MAX_WR_OUT+1)-1:0]   wr_out_cnt,
    output logic                              sched_idle,
    output logic                              sched_err
);

    localparam int AW  = (SCHED_DEPTH > 1) ? $clog2(SCHED_DEPTH) : 1;
    localparam int OW  = $clog2(SCHED_DEPTH + 1);
    localparam int RCW = $clog2(MAX_RD_OUT + 1);
    localparam int WCW = $clog2(MAX_WR_OUT + 1);
    localparam logic [OW-1:0]  OCC_FULL = OW'(SCHED_DEPTH);
    localparam logic [RCW-1:0] RD_MAX   = RCW'(MAX_RD_OUT);
    localparam logic [WCW-1:0] WR_MAX   = WCW'(MAX_WR_OUT);

    // Same layout as the interface's directory_entry_t.
    typedef struct packed {
        logic        is_write;
        logic [3:0]  tag;
        logic [31:0] addr;
    } entry_t;

    entry_t          mem [SCHED_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [OW-1:0]   occ;

    entry_t head;
    logic   head_valid;
    logic   fifo_full;
    logic   push;
    logic   pop;
    logic   rd_inc;
    logic   wr_inc;
    logic   rd_hazard;
    logic   wr_hazard;

    // Head decode, strict-order hazard and issue handshakes.
    always_comb begin
        head       = mem[rd_ptr];
        head_valid = (occ != '0);
        fifo_full  = (occ == OCC_FULL);
        // In strict mode a direction change waits for the other side to drain.
        rd_hazard  = order_strict & (wr_out_cnt != '0);
        wr_hazard  = order_strict & (rd_out_cnt != '0);

        bus.dir_mgr_pop_ready = !preset & sched_en & !fifo_full;
        bus.issue_entry       = head_valid ? head : '0;
        bus.rd_issue_valid    = head_valid & !head.is_write & sched_en &
                                (rd_out_cnt < RD_MAX) & !rd_hazard;
        bus.wr_issue_valid    = head_valid &  head.is_write & sched_en &
                                (wr_out_cnt < WR_MAX) & !wr_hazard;

        push       = bus.dir_mgr_pop_valid & bus.dir_mgr_pop_ready;
        rd_inc     = bus.rd_issue_valid & bus.rd_issue_ready;
        wr_inc     = bus.wr_issue_valid & bus.wr_issue_ready;
        pop        = rd_inc | wr_inc;
        sched_idle = !head_valid & (rd_out_cnt == '0) & (wr_out_cnt == '0);
    end

    // Staging FIFO storage, wrapping pointers and occupancy.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < SCHED_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.dir_mgr_pop_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Outstanding counters; a completion with nothing outstanding is flagged and ignored.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rd_out_cnt <= '0;
            wr_out_cnt <= '0;
            sched_err  <= 1'b0;
        end else begin
            if (rd_inc & !bus.rd_cpl)
                rd_out_cnt <= rd_out_cnt + 1'b1;
            else if (!rd_inc & bus.rd_cpl & (rd_out_cnt != '0))
                rd_out_cnt <= rd_out_cnt - 1'b1;

            if (wr_inc & !bus.wr_cpl)
                wr_out_cnt <= wr_out_cnt + 1'b1;
            else if (!wr_inc & bus.wr_cpl & (wr_out_cnt != '0))
                wr_out_cnt <= wr_out_cnt - 1'b1;

            if ((!rd_inc & bus.rd_cpl & (rd_out_cnt == '0)) |
                (!wr_inc & bus.wr_cpl & (wr_out_cnt == '0)))
                sched_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_apb2axi_txn_scheduler.sv
module tb_apb2axi_txn_scheduler;

    logic       pclk = 1'b0;
    logic       preset;
    logic       sched_en;
    logic       order_strict;
    logic [2:0] rd_out_cnt;
    logic [2:0] wr_out_cnt;
    logic       sched_idle;
    logic       sched_err;

    int tests = 0;
    int fails = 0;

    apb2axi_txn_scheduler_if bus ();

    apb2axi_txn_scheduler #(
        .SCHED_DEPTH (2),
        .MAX_RD_OUT  (4),
        .MAX_WR_OUT  (4)
    ) dut (
        .pclk         (pclk),
        .preset       (preset),
        .sched_en     (sched_en),
        .order_strict (order_strict),
        .bus          (bus),
        .rd_out_cnt   (rd_out_cnt),
        .wr_out_cnt   (wr_out_cnt),
        .sched_idle   (sched_idle),
        .sched_err    (sched_err)
    );

    always #5 pclk = ~pclk;

    function automatic logic [36:0] mk(input logic w, input logic [3:0] tag);
        return {w, tag, 32'h1000_0000 | {24'h0, tag, 4'h0}};
    endfunction

    // Advance one clock; inputs change and outputs are sampled around the falling edge.
    task automatic step();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic test_reset();
        sched_en = 1'b1;
        #1;
        tests++; if (bus.dir_mgr_pop_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b exp 0", bus.dir_mgr_pop_ready); end
        tests++; if (bus.rd_issue_valid !== 1'b0) begin fails++; $display("FAIL rst_rd_valid got %b exp 0", bus.rd_issue_valid); end
        tests++; if (bus.wr_issue_valid !== 1'b0) begin fails++; $display("FAIL rst_wr_valid got %b exp 0", bus.wr_issue_valid); end
        tests++; if (bus.issue_entry !== 37'h0) begin fails++; $display("FAIL rst_entry got %h exp 0", bus.issue_entry); end
        tests++; if (sched_idle !== 1'b1) begin fails++; $display("FAIL rst_idle got %b exp 1", sched_idle); end
        tests++; if ({rd_out_cnt, wr_out_cnt, sched_err} !== 7'h0) begin fails++; $display("FAIL rst_cnts got %b exp 0", {rd_out_cnt, wr_out_cnt, sched_err}); end
        @(negedge pclk);
        preset = 1'b0;
        #1;
        tests++; if (bus.dir_mgr_pop_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready got %b exp 1", bus.dir_mgr_pop_ready); end
    endtask

    task automatic test_basic_read();
        bus.rd_issue_ready    = 1'b1;
        bus.dir_mgr_pop_valid = 1'b1;
        bus.dir_mgr_pop_entry = mk(1'b0, 4'd3);
        #1;
        tests++; if (bus.rd_issue_valid !== 1'b0) begin fails++; $display("FAIL basic_no_passthru got %b exp 0", bus.rd_issue_valid); end
        step();
        bus.dir_mgr_pop_valid = 1'b0;
        #1;
        tests++; if (bus.rd_issue_valid !== 1'b1) begin fails++; $display("FAIL basic_rd_valid got %b exp 1", bus.rd_issue_valid); end
        tests++; if (bus.issue_entry.tag !== 4'd3) begin fails++; $display("FAIL basic_tag got %0d exp 3", bus.issue_entry.tag); end
        tests++; if (rd_out_cnt !== 3'd0) begin fails++; $display("FAIL basic_cnt0 got %0d exp 0", rd_out_cnt); end
        step();
        #1;
        tests++; if (rd_out_cnt !== 3'd1) begin fails++; $display("FAIL basic_cnt1 got %0d exp 1", rd_out_cnt); end
        tests++; if ({bus.rd_issue_valid, sched_idle} !== 2'b00) begin fails++; $display("FAIL basic_busy got %b exp 00", {bus.rd_issue_valid, sched_idle}); end
        bus.rd_cpl = 1'b1;
        step();
        bus.rd_cpl = 1'b0;
        #1;
        tests++; if (rd_out_cnt !== 3'd0) begin fails++; $display("FAIL basic_cpl_cnt got %0d exp 0", rd_out_cnt); end
        tests++; if (sched_idle !== 1'b1) begin fails++; $display("FAIL basic_idle got %b exp 1", sched_idle); end
    endtask

    task automatic test_outstanding_limit();
        bus.rd_issue_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.dir_mgr_pop_valid = 1'b1;
            bus.dir_mgr_pop_entry = mk(1'b0, 4'(i));
            step();
        end
        bus.dir_mgr_pop_valid = 1'b0;
        step();
        step();
        #1;
        tests++; if (rd_out_cnt !== 3'd4) begin fails++; $display("FAIL limit_cnt got %0d exp 4", rd_out_cnt); end
        tests++; if (bus.rd_issue_valid !== 1'b0) begin fails++; $display("FAIL limit_held got %b exp 0", bus.rd_issue_valid); end
        tests++; if (bus.issue_entry.tag !== 4'd4) begin fails++; $display("FAIL limit_head got %0d exp 4", bus.issue_entry.tag); end
        bus.rd_cpl = 1'b1;
        step();
        bus.rd_cpl = 1'b0;
        #1;
        tests++; if ({bus.rd_issue_valid, rd_out_cnt} !== {1'b1, 3'd3}) begin fails++; $display("FAIL limit_release got %b exp 1011", {bus.rd_issue_valid, rd_out_cnt}); end
        step();
        #1;
        tests++; if (rd_out_cnt !== 3'd4) begin fails++; $display("FAIL limit_reissue_cnt got %0d exp 4", rd_out_cnt); end
        tests++; if (bus.issue_entry !== 37'h0) begin fails++; $display("FAIL limit_empty_entry got %h exp 0", bus.issue_entry); end
        bus.rd_cpl = 1'b1;
        repeat (4) step();
        bus.rd_cpl = 1'b0;
        #1;
        tests++; if ({rd_out_cnt, sched_err, sched_idle} !== {3'd0, 1'b0, 1'b1}) begin fails++; $display("FAIL limit_drain got %b exp 00001", {rd_out_cnt, sched_err, sched_idle}); end
    endtask

    task automatic test_strict_order();
        bus.rd_issue_ready = 1'b1;
        bus.wr_issue_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            order_strict = (pass == 0);
            bus.dir_mgr_pop_valid = 1'b1;
            bus.dir_mgr_pop_entry = mk(1'b0, 4'd5);
            step();
            bus.dir_mgr_pop_entry = mk(1'b1, 4'd6);
            step();
            bus.dir_mgr_pop_valid = 1'b0;
            #1;
            tests++; if (rd_out_cnt !== 3'd1) begin fails++; $display("FAIL order_rd_cnt pass %0d got %0d exp 1", pass, rd_out_cnt); end
            tests++; if (bus.wr_issue_valid !== (pass == 1)) begin fails++; $display("FAIL order_wr_valid pass %0d got %b exp %b", pass, bus.wr_issue_valid, pass == 1); end
            if (pass == 0) begin
                step();
                bus.rd_cpl = 1'b1;
                #1;
                tests++; if (bus.wr_issue_valid !== 1'b0) begin fails++; $display("FAIL order_still_blocked got %b exp 0", bus.wr_issue_valid); end
                step();
                bus.rd_cpl = 1'b0;
                #1;
                tests++; if ({rd_out_cnt, bus.wr_issue_valid} !== {3'd0, 1'b1}) begin fails++; $display("FAIL order_unblock got %b exp 0001", {rd_out_cnt, bus.wr_issue_valid}); end
                step();
                #1;
                tests++; if (wr_out_cnt !== 3'd1) begin fails++; $display("FAIL order_wr_cnt got %0d exp 1", wr_out_cnt); end
                bus.wr_cpl = 1'b1;
                step();
                bus.wr_cpl = 1'b0;
            end else begin
                step();
                #1;
                tests++; if ({rd_out_cnt, wr_out_cnt} !== {3'd1, 3'd1}) begin fails++; $display("FAIL relaxed_cnts got %b exp 001001", {rd_out_cnt, wr_out_cnt}); end
                bus.rd_cpl = 1'b1;
                bus.wr_cpl = 1'b1;
                step();
                bus.rd_cpl = 1'b0;
                bus.wr_cpl = 1'b0;
            end
        end
        order_strict = 1'b0;
        bus.wr_issue_ready = 1'b0;
        #1;
        tests++; if ({sched_idle, sched_err} !== 2'b10) begin fails++; $display("FAIL order_idle got %b exp 10", {sched_idle, sched_err}); end
    endtask

    task automatic test_full_fifo();
        bus.rd_issue_ready = 1'b0;
        bus.wr_issue_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bus.dir_mgr_pop_valid = 1'b1;
            bus.dir_mgr_pop_entry = mk(1'b0, 4'(i));
            #1;
            tests++; if (bus.dir_mgr_pop_ready !== (i < 3)) begin fails++; $display("FAIL full_ready push %0d got %b exp %b", i, bus.dir_mgr_pop_ready, i < 3); end
            step();
        end
        bus.dir_mgr_pop_valid = 1'b0;
        #1;
        tests++; if ({bus.dir_mgr_pop_ready, bus.issue_entry.tag} !== {1'b0, 4'd1}) begin fails++; $display("FAIL full_hold got %b exp 00001", {bus.dir_mgr_pop_ready, bus.issue_entry.tag}); end
        bus.rd_issue_ready = 1'b1;
        step();
        bus.rd_issue_ready = 1'b0;
        #1;
        tests++; if ({bus.dir_mgr_pop_ready, bus.issue_entry.tag} !== {1'b1, 4'd2}) begin fails++; $display("FAIL full_pop got %b exp 10010", {bus.dir_mgr_pop_ready, bus.issue_entry.tag}); end
        bus.rd_issue_ready = 1'b1;
        step();
        bus.rd_issue_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        #1;
        tests++; if (rd_out_cnt !== 3'd2) begin fails++; $display("FAIL simul_pre got %0d exp 2", rd_out_cnt); end
        bus.dir_mgr_pop_valid = 1'b1;
        bus.dir_mgr_pop_entry = mk(1'b0, 4'd9);
        step();
        bus.dir_mgr_pop_valid = 1'b0;
        bus.rd_issue_ready = 1'b1;
        bus.rd_cpl = 1'b1;
        step();
        bus.rd_issue_ready = 1'b0;
        bus.rd_cpl = 1'b0;
        #1;
        tests++; if ({rd_out_cnt, sched_err} !== {3'd2, 1'b0}) begin fails++; $display("FAIL simul_cnt got %b exp 0100", {rd_out_cnt, sched_err}); end
        bus.rd_cpl = 1'b1;
        repeat (3) step();
        bus.rd_cpl = 1'b0;
        #1;
        tests++; if ({rd_out_cnt, sched_err} !== {3'd0, 1'b1}) begin fails++; $display("FAIL underflow got %b exp 0001", {rd_out_cnt, sched_err}); end
        bus.wr_cpl = 1'b1;
        step();
        bus.wr_cpl = 1'b0;
        step();
        #1;
        tests++; if ({wr_out_cnt, sched_err} !== {3'd0, 1'b1}) begin fails++; $display("FAIL err_sticky got %b exp 0001", {wr_out_cnt, sched_err}); end
    endtask

    task automatic test_reset_mid_op();
        bus.wr_issue_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.dir_mgr_pop_valid = 1'b1;
            bus.dir_mgr_pop_entry = mk(1'b1, 4'(i));
            step();
        end
        bus.dir_mgr_pop_valid = 1'b0;
        step();
        bus.wr_issue_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.dir_mgr_pop_valid = 1'b1;
            bus.dir_mgr_pop_entry = mk(1'b1, 4'(i + 12));
            step();
        end
        bus.dir_mgr_pop_valid = 1'b0;
        #1;
        tests++; if ({wr_out_cnt, bus.wr_issue_valid, bus.dir_mgr_pop_ready} !== {3'd3, 1'b1, 1'b0}) begin fails++; $display("FAIL midop_pre got %b exp 01110", {wr_out_cnt, bus.wr_issue_valid, bus.dir_mgr_pop_ready}); end
        #1;
        preset = 1'b1;
        #1;
        tests++; if ({bus.dir_mgr_pop_ready, bus.wr_issue_valid, bus.rd_issue_valid} !== 3'b000) begin fails++; $display("FAIL midop_valids got %b exp 000", {bus.dir_mgr_pop_ready, bus.wr_issue_valid, bus.rd_issue_valid}); end
        tests++; if (bus.issue_entry !== 37'h0) begin fails++; $display("FAIL midop_entry got %h exp 0", bus.issue_entry); end
        tests++; if ({wr_out_cnt, rd_out_cnt, sched_err, sched_idle} !== 8'b0000_0001) begin fails++; $display("FAIL midop_state got %b exp 00000001", {wr_out_cnt, rd_out_cnt, sched_err, sched_idle}); end
        step();
        preset = 1'b0;
        #1;
        tests++; if ({sched_idle, sched_err} !== 2'b10) begin fails++; $display("FAIL midop_release got %b exp 10", {sched_idle, sched_err}); end
        bus.dir_mgr_pop_valid = 1'b1;
        bus.dir_mgr_pop_entry = mk(1'b0, 4'd10);
        step();
        bus.dir_mgr_pop_valid = 1'b0;
        #1;
        tests++; if ({bus.rd_issue_valid, bus.issue_entry.tag} !== {1'b1, 4'd10}) begin fails++; $display("FAIL midop_first_push got %b exp 11010", {bus.rd_issue_valid, bus.issue_entry.tag}); end
    endtask

    initial begin
        preset                = 1'b1;
        sched_en              = 1'b0;
        order_strict          = 1'b0;
        bus.dir_mgr_pop_valid = 1'b0;
        bus.dir_mgr_pop_entry = '0;
        bus.rd_issue_ready    = 1'b0;
        bus.wr_issue_ready    = 1'b0;
        bus.rd_cpl            = 1'b0;
        bus.wr_cpl            = 1'b0;
        repeat (2) @(negedge pclk);
        test_reset();
        test_basic_read();
        test_outstanding_limit();
        test_strict_order();
        test_full_fifo();
        test_simultaneous();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
